// File: rtl/win33_ewmm_if.sv
// Port bundle for the Winograd F(2x2,3x3) element-wise multiply stage:
// start request, U/V tile rows in, M rows plus completion/busy status out.
interface win33_ewmm_if;
  logic         enable;
  logic [127:0] u_tmp1, u_tmp2, u_tmp3, u_tmp4;
  logic [127:0] v_tmp1, v_tmp2, v_tmp3, v_tmp4;
  logic [127:0] m_tmp1, m_tmp2, m_tmp3, m_tmp4;
  logic         end_signal;
  logic         busy;

  modport master (
    output enable,
    output u_tmp1, u_tmp2, u_tmp3, u_tmp4,
    output v_tmp1, v_tmp2, v_tmp3, v_tmp4,
    input  m_tmp1, m_tmp2, m_tmp3, m_tmp4,
    input  end_signal, busy
  );

  modport slave (
    input  enable,
    input  u_tmp1, u_tmp2, u_tmp3, u_tmp4,
    input  v_tmp1, v_tmp2, v_tmp3, v_tmp4,
    output m_tmp1, m_tmp2, m_tmp3, m_tmp4,
    output end_signal, busy
  );
endinterface

// File: rtl/win33_ewmm.sv
// Winograd F(2x2,3x3) element-wise multiply M = U .* V, one row per cycle.
// Optional macro WIN_EWMM_SAT_EN: saturate each shifted product to 32 bits instead of wrapping.
module win33_ewmm #(
  parameter int FRAC_BITS = 0
) (
  input  logic          clk,
  input  logic          rst,
  win33_ewmm_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL1 = 3'd1,
    S_MUL2 = 3'd2,
    S_MUL3 = 3'd3,
    S_MUL4 = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic signed [63:0] S_MAX = 64'sd2147483647;
  localparam logic signed [63:0] S_MIN = -64'sd2147483648;

  state_t state_q, state_d;

  logic [127:0]       u_rows [4];
  logic [127:0]       v_rows [4];
  logic signed [31:0] u_in   [16];
  logic signed [31:0] v_in   [16];

  logic signed [31:0] u_op_q [16];
  logic signed [31:0] u_op_d [16];
  logic signed [31:0] v_op_q [16];
  logic signed [31:0] v_op_d [16];

  logic [127:0] m_q [4];
  logic [127:0] m_d [4];
  logic         end_signal_q, end_signal_d;
  logic         busy_q, busy_d;

  logic [1:0]   row_sel;
  logic [31:0]  lane_res [4];
  logic [127:0] row_res;

  // Shift the exact product, then either wrap or clamp it into 32 bits.
  function automatic logic [31:0] fmt_product(input logic signed [63:0] p);
    logic signed [63:0] s;
    s = p >>> FRAC_BITS;
`ifdef WIN_EWMM_SAT_EN
    if (s > S_MAX) begin
      return 32'h7FFF_FFFF;
    end else if (s < S_MIN) begin
      return 32'h8000_0000;
    end
    return s[31:0];
`else
    return s[31:0];
`endif
  endfunction

  assign u_rows[0] = bus.u_tmp1;
  assign u_rows[1] = bus.u_tmp2;
  assign u_rows[2] = bus.u_tmp3;
  assign u_rows[3] = bus.u_tmp4;
  assign v_rows[0] = bus.v_tmp1;
  assign v_rows[1] = bus.v_tmp2;
  assign v_rows[2] = bus.v_tmp3;
  assign v_rows[3] = bus.v_tmp4;

  // Element gi is row gi/4, lane gi%4; lane 0 sits in the top 32 bits.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
      assign u_in[gi] = u_rows[gi / 4][127 - 32 * (gi % 4) -: 32];
      assign v_in[gi] = v_rows[gi / 4][127 - 32 * (gi % 4) -: 32];
    end
  endgenerate

  // MUL1..MUL4 encode as 1..4, so state-1 (mod 4) is the row being multiplied.
  assign row_sel = state_q[1:0] - 2'd1;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [3:0]         idx;
      logic signed [63:0] prod;
      assign idx           = {row_sel, 2'(gi)};
      assign prod          = 64'(u_op_q[idx]) * 64'(v_op_q[idx]);
      assign lane_res[gi]  = fmt_product(prod);
    end
  endgenerate

  assign row_res = {lane_res[0], lane_res[1], lane_res[2], lane_res[3]};

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      end_signal_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        u_op_q[i] <= '0;
        v_op_q[i] <= '0;
      end
      for (int r = 0; r < 4; r++) begin
        m_q[r] <= '0;
      end
    end else begin
      state_q      <= state_d;
      end_signal_q <= end_signal_d;
      busy_q       <= busy_d;
      for (int i = 0; i < 16; i++) begin
        u_op_q[i] <= u_op_d[i];
        v_op_q[i] <= v_op_d[i];
      end
      for (int r = 0; r < 4; r++) begin
        m_q[r] <= m_d[r];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = bus.enable ? S_MUL1 : S_IDLE;
      S_MUL1:  state_d = S_MUL2;
      S_MUL2:  state_d = S_MUL3;
      S_MUL3:  state_d = S_MUL4;
      S_MUL4:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; status flags are registered copies of the next state.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      u_op_d[i] = u_op_q[i];
      v_op_d[i] = v_op_q[i];
    end
    for (int r = 0; r < 4; r++) begin
      m_d[r] = m_q[r];
    end
    end_signal_d = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);

    if (state_q == S_IDLE && bus.enable) begin
      for (int i = 0; i < 16; i++) begin
        u_op_d[i] = u_in[i];
        v_op_d[i] = v_in[i];
      end
    end

    if (state_q == S_MUL1 || state_q == S_MUL2 ||
        state_q == S_MUL3 || state_q == S_MUL4) begin
      m_d[row_sel] = row_res;
    end
  end

  assign bus.m_tmp1     = m_q[0];
  assign bus.m_tmp2     = m_q[1];
  assign bus.m_tmp3     = m_q[2];
  assign bus.m_tmp4     = m_q[3];
  assign bus.end_signal = end_signal_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_win33_ewmm.sv
// Directed bench for win33_ewmm: two instances (FRAC_BITS 0 and 8) share stimulus,
// expected tiles are queued at launch and popped when end_signal appears.
module tb_win33_ewmm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  win33_ewmm_if b0 ();
  win33_ewmm_if b8 ();

  win33_ewmm #(.FRAC_BITS(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  win33_ewmm #(.FRAC_BITS(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

  typedef logic [3:0][127:0] tile_t;
  typedef struct {
    tile_t m0;
    tile_t m8;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] row4(input int a, input int b, input int c, input int d);
    return {32'(a), 32'(b), 32'(c), 32'(d)};
  endfunction

  function automatic logic [31:0] ref_elem(input logic [31:0] u, input logic [31:0] v, input int frac);
    logic signed [63:0] p;
    logic signed [63:0] s;
    p = 64'($signed(u)) * 64'($signed(v));
    s = p >>> frac;
`ifdef WIN_EWMM_SAT_EN
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  function automatic tile_t ref_tile(input tile_t u, input tile_t v, input int frac);
    tile_t m;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        m[r][127 - 32 * j -: 32] = ref_elem(u[r][127 - 32 * j -: 32], v[r][127 - 32 * j -: 32], frac);
    return m;
  endfunction

  task automatic set_inputs(input tile_t u, input tile_t v);
    b0.u_tmp1 = u[0]; b0.u_tmp2 = u[1]; b0.u_tmp3 = u[2]; b0.u_tmp4 = u[3];
    b0.v_tmp1 = v[0]; b0.v_tmp2 = v[1]; b0.v_tmp3 = v[2]; b0.v_tmp4 = v[3];
    b8.u_tmp1 = u[0]; b8.u_tmp2 = u[1]; b8.u_tmp3 = u[2]; b8.u_tmp4 = u[3];
    b8.v_tmp1 = v[0]; b8.v_tmp2 = v[1]; b8.v_tmp3 = v[2]; b8.v_tmp4 = v[3];
  endtask

  task automatic set_enable(input logic en);
    b0.enable = en;
    b8.enable = en;
  endtask

  // Leaves the bench at the first falling edge after the accepting edge.
  task automatic launch(input tile_t u, input tile_t v, input bit push);
    exp_t e;
    @(negedge clk);
    set_inputs(u, v);
    set_enable(1'b1);
    if (push) begin
      e.m0 = ref_tile(u, v, 0);
      e.m8 = ref_tile(u, v, 8);
      sb.push_back(e);
    end
    @(negedge clk);
    set_enable(1'b0);
    chk("busy_after_accept", 128'(b0.busy), 128'(1'b1));
  endtask

  function automatic tile_t obs_tile0();
    return {b0.m_tmp4, b0.m_tmp3, b0.m_tmp2, b0.m_tmp1};
  endfunction

  function automatic tile_t obs_tile8();
    return {b8.m_tmp4, b8.m_tmp3, b8.m_tmp2, b8.m_tmp1};
  endfunction

  task automatic pop_compare(input string tag);
    exp_t  e;
    tile_t o0, o8;
    chk({tag, "_sb_nonempty"}, 128'(sb.size() > 0), 128'(1'b1));
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      o0 = obs_tile0();
      o8 = obs_tile8();
      for (int r = 0; r < 4; r++) begin
        chk($sformatf("%s_f0_row%0d", tag, r + 1), o0[r], e.m0[r]);
        chk($sformatf("%s_f8_row%0d", tag, r + 1), o8[r], e.m8[r]);
      end
    end
  endtask

  // cyc = number of accepting-edge-relative falling edges already seen.
  task automatic wait_done(input string tag, input int start_cyc);
    int cyc;
    cyc = start_cyc;
    while (b0.end_signal !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 128'(cyc), 128'(5));
    chk({tag, "_end_f8"}, 128'(b8.end_signal), 128'(1'b1));
    chk({tag, "_busy_in_done"}, 128'(b0.busy), 128'(1'b1));
    pop_compare(tag);
    @(negedge clk);
    chk({tag, "_end_drop"}, 128'(b0.end_signal), 128'(1'b0));
    chk({tag, "_busy_drop"}, 128'(b0.busy), 128'(1'b0));
  endtask

  initial begin
    tile_t u, v, u2, exp_a, prev;
    int    pulses;
    int    first_at, second_at;

    rst = 1'b1;
    set_enable(1'b0);
    set_inputs('0, '0);
    repeat (3) @(negedge clk);
    // Enable asserted together with reset must not start a job.
    set_enable(1'b1);
    @(negedge clk);
    chk("rst_m1", b0.m_tmp1, '0);
    chk("rst_m4", b0.m_tmp4, '0);
    chk("rst_m2_f8", b8.m_tmp2, '0);
    chk("rst_busy", 128'(b0.busy), '0);
    chk("rst_end", 128'(b0.end_signal), '0);
    set_enable(1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 128'(b0.busy), '0);

    // Basic products: 3*5 everywhere.
    u = {4{row4(3, 3, 3, 3)}};
    v = {4{row4(5, 5, 5, 5)}};
    launch(u, v, 1'b1);
    wait_done("basic", 1);
    chk("basic_const_m3", b0.m_tmp3, row4(15, 15, 15, 15));

    // Signed values and lane order; rows 2-4 random.
    u[0] = row4(-2, 7, 0, -1);
    v[0] = row4(4, -3, 9, -1);
    for (int r = 1; r < 4; r++) begin
      u[r] = {$urandom, $urandom, $urandom, $urandom};
      v[r] = {$urandom, $urandom, $urandom, $urandom};
    end
    launch(u, v, 1'b1);
    wait_done("signed", 1);
    chk("signed_const_m1", b0.m_tmp1, row4(-8, -21, 0, 1));
    prev = obs_tile0();

    // Fixed-point: 1.5 * -2.0 = -3.0 and truncation toward -inf.
    u = '0; v = '0;
    u[0] = {32'h0000_0180, 32'h0000_0001, 64'h0};
    v[0] = {32'hFFFF_FE00, 32'hFFFF_FFFF, 64'h0};
    launch(u, v, 1'b1);
    wait_done("fixpt", 1);
    chk("fixpt_const_m1", b8.m_tmp1, {32'hFFFF_FD00, 32'hFFFF_FFFF, 64'h0});

    // Overflow: +2^32 and -2^32 products.
    u = '0; v = '0;
    u[0] = {32'h0001_0000, 32'h0001_0000, 64'h0};
    v[0] = {32'h0001_0000, 32'hFFFF_0000, 64'h0};
    launch(u, v, 1'b1);
    wait_done("ovf", 1);
`ifdef WIN_EWMM_SAT_EN
    chk("ovf_const_m1", b0.m_tmp1, {32'h7FFF_FFFF, 32'h8000_0000, 64'h0});
`else
    chk("ovf_const_m1", b0.m_tmp1, 128'h0);
`endif
    prev = obs_tile0();

    // Input isolation plus row-by-row write order.
    for (int r = 0; r < 4; r++) begin
      u[r] = {$urandom_range(1, 999), $urandom_range(1, 999), $urandom_range(1, 999), $urandom_range(1, 999)};
      v[r] = {$urandom_range(1, 999), $urandom_range(1, 999), $urandom_range(1, 999), $urandom_range(1, 999)};
      u2[r] = ~u[r];
    end
    exp_a = ref_tile(u, v, 0);
    launch(u, v, 1'b1);
    @(negedge clk);
    chk("iso_row1_early", b0.m_tmp1, exp_a[0]);
    chk("iso_row2_hold", b0.m_tmp2, prev[1]);
    set_inputs(u2, v);
    wait_done("iso", 2);

    // Enable held for 10 cycles: accepts at E0 and E6 only.
    u = {4{row4(-7, 11, 13, -17)}};
    v = {4{row4(19, -23, 29, 31)}};
    @(negedge clk);
    set_inputs(u, v);
    set_enable(1'b1);
    sb.push_back('{m0: ref_tile(u, v, 0), m8: ref_tile(u, v, 8)});
    sb.push_back('{m0: ref_tile(u, v, 0), m8: ref_tile(u, v, 8)});
    pulses = 0; first_at = -1; second_at = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 10) set_enable(1'b0);
      if (b0.end_signal === 1'b1) begin
        pulses++;
        if (pulses == 1) first_at = i;
        if (pulses == 2) second_at = i;
        pop_compare("hold");
      end
    end
    chk("hold_pulses", 128'(pulses), 128'(2));
    chk("hold_first_at", 128'(first_at), 128'(5));
    chk("hold_second_at", 128'(second_at), 128'(11));

    // Reset during MUL3 aborts the job.
    launch(u, v, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_m1", b0.m_tmp1, '0);
    chk("midrst_m2", b0.m_tmp2, '0);
    chk("midrst_m4_f8", b8.m_tmp4, '0);
    chk("midrst_busy", 128'(b0.busy), '0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (b0.end_signal === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("midrst_no_end", 128'(pulses), 128'(0));
    chk("midrst_busy_idle", 128'(b0.busy), '0);

    // Fresh job after the abort.
    u = {4{row4(100, -200, 300, -400)}};
    v = {4{row4(-5, 6, 7, -8)}};
    launch(u, v, 1'b1);
    wait_done("post_rst", 1);
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/win33_ewmm.md
# win33_ewmm

Element-wise multiply stage of the Winograd F(2x2,3x3) convolution datapath. Takes one 4x4 transformed input tile V and one 4x4 transformed filter tile U, and computes M = U ⊙ V (16 signed fixed-point products). It produces the four 128-bit M rows consumed directly by the output-transform stage. Its `end_signal` pulse drives that stage's `enable`.

## Interface

Parameters:
- `FRAC_BITS`, default 0: number of fractional bits in the operand format. Each product is arithmetic-right-shifted by this amount. Legal range is 0–31.

Ports:
- `clk` input 1: clock. All logic is rising-edge.
- `rst` input 1: reset. Synchronous, active-high.
- `enable` input 1: start request. Sampled only in IDLE.
- `u_tmp1`..`u_tmp4` input 128 each: filter tile rows 1–4. Packing is {x_1,x_2,x_3,x_4}, with x_1 in [127:96]. Each element is 32-bit signed.
- `v_tmp1`..`v_tmp4` input 128 each: input tile rows 1–4. Same packing as `u_tmp*`.
- `m_tmp1`..`m_tmp4` output 128 each: product rows 1–4. Same packing. Registered.
- `end_signal` output 1: one-cycle completion pulse, registered. High = `Finish`, low = `UnFinish`.
- `busy` output 1: high from job acceptance until the DONE cycle ends. Registered.

## Operation

- **States:** IDLE, MUL1, MUL2, MUL3, MUL4, DONE. Encoding is 3-bit. Unused encodings go to IDLE.
- **IDLE:**
  - When `enable`=1, latch all 16 U and 16 V elements into internal operand registers, then go to MUL1.
  - Otherwise stay in IDLE.
- **MULk (k=1..4):**
  - Four parallel 32x32 signed multipliers process row k, elements 1–4.
  - Results are written into `m_tmpk` at the edge that leaves MULk.
  - Transitions: MUL1 → MUL2 → MUL3 → MUL4 → DONE. Each state lasts exactly one cycle.
- **DONE:** `end_signal`=1 for this single cycle, then the FSM returns to IDLE unconditionally.
- **Per-element arithmetic:**
  - p = $signed(u) * $signed(v), 64-bit exact.
  - s = p >>> FRAC_BITS (arithmetic shift; truncation toward −inf).
  - Default: m = s[31:0], with two's-complement wrap.
- **Operand isolation:**
  - Inputs are sampled only on the accepting edge.
  - Later changes on `u_tmp*`/`v_tmp*` do not affect the job in flight.
- **Output holding:**
  - `m_tmp*` hold their values after DONE until overwritten by the next job's MULk writes.
  - Rows are overwritten one per cycle, starting with row 1.
- **Busy behaviour:** `enable` asserted in MUL1..MUL4 or DONE is ignored and is not queued.

## Timing

- **Reset values:** on `rst`=1 at a clock edge:
  - State = IDLE.
  - `m_tmp1`..`m_tmp4` = 0.
  - Operand registers = 0.
  - `end_signal` = 0.
  - `busy` = 0.
- **Job timeline** (edge E0 is the one that samples `enable`=1 in IDLE):
  - `busy`=1 after E0.
  - `m_tmp1` is valid after E1, `m_tmp2` after E2, `m_tmp3` after E3, `m_tmp4` after E4.
  - `end_signal`=1 in the cycle after E4. `busy` remains 1 in that cycle.
  - After E5: `end_signal`=0, `busy`=0, state is IDLE.
- **Latency and throughput:**
  - Latency from accepting edge to `end_signal` high: 4 cycles.
  - Minimum spacing between accepting edges: 6 cycles.
- **Downstream guarantee:** all four `m_tmp*` rows stay stable from E4 through at least E6. This covers the output transform's first compute cycle, which follows its `enable` sample.
- **Reset mid-job:**
  - The job is aborted and no `end_signal` is produced.
  - Outputs clear to 0 at the reset edge.
- **`rst` and `enable` together:** reset wins and no job is accepted.

## Configuration

- Macro: `WIN_EWMM_SAT_EN`.
- **Defined:**
  - m = s clamped to [−2^31, 2^31−1].
  - s > 2^31−1 gives 32'h7FFF_FFFF.
  - s < −2^31 gives 32'h8000_0000.
- **Undefined:** m = s[31:0], with wrap-around.
- Timing, latency and the FSM are identical in both builds.

## Test plan

- **Basic products:** FRAC_BITS=0, all u=3, all v=5, pulse `enable`.
  - Every element of `m_tmp1`..`m_tmp4` = 15.
  - `end_signal` is high for exactly 1 cycle, 4 cycles after the accept edge.
- **Signed values and lane order:** FRAC_BITS=0, row1 u={−2,7,0,−1}, v={4,−3,9,−1}.
  - `m_tmp1` = {−8,−21,0,1}, with x_1 at [127:96].
  - Rows 2–4 are checked against a reference model.
- **Fixed-point shift:** FRAC_BITS=8, u=0x0180 (1.5), v=0xFE00 (−2.0, sign-extended).
  - m = 0xFFFFFD00 (−3.0).
  - u=1, v=−1 gives −1 (truncation toward −inf).
- **Overflow:** FRAC_BITS=0, u=v=0x0001_0000.
  - Without the macro: m=0.
  - With `WIN_EWMM_SAT_EN`: m=0x7FFF_FFFF.
  - u=0x0001_0000, v=−0x0001_0000 saturates to 0x8000_0000.
- **Busy and input isolation:**
  - Hold `enable` high for 10 cycles: exactly 2 jobs complete, at accept edges E0 and E6.
  - Change `u_tmp*` during MUL2: results reflect only the values latched at E0.
- **Reset mid-job:** assert `rst` in MUL3.
  - The next cycle shows all `m_tmp*`=0, `busy`=0 and state IDLE.
  - No `end_signal` pulse occurs.
  - A new job started afterwards completes normally.
